// File: rtl/ker_clk_src_switch_ctrl.sv
// Glitch-free kernel-clock source switch: gate the kernel clock, request and await the
// new oscillator, switch the applied select, let it settle, then ungate.
module ker_clk_src_switch_ctrl #(
   parameter int KER_CLK_SRC_NUM = 5,
   parameter int SEL_W           = 3,
   parameter int DEFAULT_SEL     = 0,
   parameter int OFF_CYCLES      = 2,
   parameter int ON_CYCLES       = 2,
   parameter int RDY_TIMEOUT     = 255,
   parameter int TMO_W           = 8
) (
   input  logic                       i_clk,
   input  logic                       rst_n,
   input  logic [SEL_W-1:0]           sel_req,
   input  logic [KER_CLK_SRC_NUM-1:0] src_rdy,
   input  logic                       testmode,
   input  logic                       err_clr,
   output logic [SEL_W-1:0]           ker_clk_sel,
   output logic                       ker_gate_en,
   output logic [KER_CLK_SRC_NUM-1:0] src_on_req,
   output logic                       busy,
   output logic                       sel_err,
   output logic                       tmo_err
);

   localparam logic [2:0] ST_RUN      = 3'd0;
   localparam logic [2:0] ST_GATE_OFF = 3'd1;
   localparam logic [2:0] ST_WAIT_RDY = 3'd2;
   localparam logic [2:0] ST_SWITCH   = 3'd3;
   localparam logic [2:0] ST_SETTLE   = 3'd4;

   localparam logic [SEL_W:0]           SRC_NUM = (SEL_W+1)'(KER_CLK_SRC_NUM);
   localparam logic [SEL_W-1:0]         DEF_SEL = SEL_W'(DEFAULT_SEL);
   localparam logic [TMO_W-1:0]         CNT_OFF = TMO_W'(OFF_CYCLES);
   localparam logic [TMO_W-1:0]         CNT_ON  = TMO_W'(ON_CYCLES);
   localparam logic [TMO_W-1:0]         CNT_TMO = TMO_W'(RDY_TIMEOUT);
   localparam logic [TMO_W-1:0]         CNT_ONE = TMO_W'(1);
   localparam logic [KER_CLK_SRC_NUM-1:0] OH_ONE = {{(KER_CLK_SRC_NUM-1){1'b0}}, 1'b1};

   function automatic logic [KER_CLK_SRC_NUM-1:0] one_hot(input logic [SEL_W-1:0] s);
      return OH_ONE << s;
   endfunction

   logic [2:0]       state_q, state_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             gate_q, gate_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] tgt_q, tgt_d;
   logic             sel_err_q, sel_err_d;
   logic             tmo_err_q, tmo_err_d;
   logic             start;
   logic             sel_invalid;

   assign sel_invalid = ({1'b0, sel_req} >= SRC_NUM);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gate_d    = gate_q;
      sel_d     = sel_q;
      tgt_d     = tgt_q;
      sel_err_d = sel_err_q & ~err_clr;
      tmo_err_d = tmo_err_q & ~err_clr;
      start     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (sel_req != sel_q) begin
               if (sel_invalid) begin
                  sel_err_d = 1'b1;
               end else begin
                  start   = 1'b1;
                  tgt_d   = sel_req;
                  cnt_d   = CNT_OFF;
                  gate_d  = 1'b0;
                  state_d = ST_GATE_OFF;
               end
            end
         end
         ST_GATE_OFF: begin
            if (cnt_q == CNT_ONE) begin
               cnt_d   = CNT_TMO;
               state_d = ST_WAIT_RDY;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_WAIT_RDY: begin
            // A ready flag arriving on the last allowed cycle still wins over the timeout.
            if (src_rdy[tgt_q]) begin
               state_d = ST_SWITCH;
            end else if (cnt_q == CNT_ONE) begin
               tmo_err_d = 1'b1;
               cnt_d     = CNT_ON;
               state_d   = ST_SETTLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_SWITCH: begin
            sel_d   = tgt_q;
            cnt_d   = CNT_ON;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_ONE) begin
               gate_d  = 1'b1;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            gate_d  = 1'b1;
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         gate_q    <= 1'b1;
         sel_q     <= DEF_SEL;
         tgt_q     <= DEF_SEL;
         sel_err_q <= 1'b0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gate_q    <= gate_d;
         sel_q     <= sel_d;
         tgt_q     <= tgt_d;
         sel_err_q <= sel_err_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   // Both oscillators stay requested while waiting and switching; on the revert path
   // sel_q never moved, so the request falls back to the old source automatically.
   assign src_on_req  = (state_q == ST_WAIT_RDY || state_q == ST_SWITCH) ?
                        (one_hot(sel_q) | one_hot(tgt_q)) : one_hot(sel_q);
   assign ker_clk_sel = sel_q;
   assign ker_gate_en = gate_q | testmode;
   assign busy        = (state_q != ST_RUN) | start;
   assign sel_err     = sel_err_q;
   assign tmo_err     = tmo_err_q;

endmodule

// File: tb/tb_ker_clk_src_switch_ctrl.sv
// Bench for ker_clk_src_switch_ctrl: a cycle table fed through an expected-value queue,
// followed by hand-written sequences for waits, timeouts, retargeting, testmode and reset.
module tb_ker_clk_src_switch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sel_req = 3'd0;
   logic [4:0] src_rdy = 5'b11111;
   logic       testmode = 1'b0;
   logic       err_clr = 1'b0;
   logic [2:0] ker_clk_sel;
   logic       ker_gate_en;
   logic [4:0] src_on_req;
   logic       busy;
   logic       sel_err;
   logic       tmo_err;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [2:0] sel;
      logic       gate;
      logic [4:0] on_req;
      logic       busy;
      logic       sel_err;
      logic       tmo_err;
   } exp_t;

   typedef struct {
      logic [2:0] sel_req;
      logic [4:0] src_rdy;
      logic       err_clr;
      exp_t       exp;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[12];

   ker_clk_src_switch_ctrl #(.RDY_TIMEOUT(16)) dut (
      .i_clk(clk),
      .rst_n(rst_n),
      .sel_req(sel_req),
      .src_rdy(src_rdy),
      .testmode(testmode),
      .err_clr(err_clr),
      .ker_clk_sel(ker_clk_sel),
      .ker_gate_en(ker_gate_en),
      .src_on_req(src_on_req),
      .busy(busy),
      .sel_err(sel_err),
      .tmo_err(tmo_err)
   );

   always #5 clk = ~clk;

   // Safety net so a stuck run still reports and ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mkVec(input logic [2:0] sr, input logic [4:0] rdy, input logic clr,
                                  input logic [2:0] s, input logic g, input logic [4:0] o,
                                  input logic b, input logic se, input logic te);
      vec_t v;
      v.sel_req     = sr;
      v.src_rdy     = rdy;
      v.err_clr     = clr;
      v.exp.sel     = s;
      v.exp.gate    = g;
      v.exp.on_req  = o;
      v.exp.busy    = b;
      v.exp.sel_err = se;
      v.exp.tmo_err = te;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         checkValue("vec_sel", 8'(ker_clk_sel), 8'(e.sel));
         checkValue("vec_gate", 8'(ker_gate_en), 8'(e.gate));
         checkValue("vec_on_req", 8'(src_on_req), 8'(e.on_req));
         checkValue("vec_busy", 8'(busy), 8'(e.busy));
         checkValue("vec_sel_err", 8'(sel_err), 8'(e.sel_err));
         checkValue("vec_tmo_err", 8'(tmo_err), 8'(e.tmo_err));
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      sel_req = v.sel_req;
      src_rdy = v.src_rdy;
      err_clr = v.err_clr;
      sb.push_back(v.exp);
      tick();
      checkOutput();
   endtask

   initial begin
      // Rows: inputs for the coming edge, outputs expected just after it.
      vecs[0]  = mkVec(3'd0, 5'h1F, 1'b0, 3'd0, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd0, 1'b0, 5'b00101, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd0, 1'b0, 5'b00101, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd2, 1'b0, 5'b00100, 1'b1, 1'b0, 1'b0);
      vecs[6]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd2, 1'b0, 5'b00100, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mkVec(3'd2, 5'h1F, 1'b0, 3'd2, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
      vecs[8]  = mkVec(3'd6, 5'h1F, 1'b0, 3'd2, 1'b1, 5'b00100, 1'b0, 1'b1, 1'b0);
      vecs[9]  = mkVec(3'd6, 5'h1F, 1'b1, 3'd2, 1'b1, 5'b00100, 1'b0, 1'b1, 1'b0);
      vecs[10] = mkVec(3'd2, 5'h1F, 1'b1, 3'd2, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
      vecs[11] = mkVec(3'd2, 5'h1F, 1'b0, 3'd2, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] table sequence: reset, 0->2 switch, invalid select and error clear");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
      end
      err_clr = 1'b0;

      $display("[TB] testmode held during a 2->0 switch");
      sel_req  = 3'd0;
      testmode = 1'b1;
      #1;
      checkValue("tm_busy_on_detect", 8'(busy), 8'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkValue("tm_gate_forced", 8'(ker_gate_en), 8'd1);
         checkValue("tm_sel_old", 8'(ker_clk_sel), 8'd2);
      end
      tick();
      checkValue("tm_sel_switched", 8'(ker_clk_sel), 8'd0);
      testmode = 1'b0;
      #1;
      checkValue("tm_gate_released", 8'(ker_gate_en), 8'd0);
      repeat (2) tick();
      checkValue("tm_gate_open", 8'(ker_gate_en), 8'd1);
      checkValue("tm_busy_done", 8'(busy), 8'd0);

      $display("[TB] 0->3 with a late ready flag");
      src_rdy = 5'b10111;
      sel_req = 3'd3;
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         checkValue("wait_on_req", 8'(src_on_req), 8'b01001);
         checkValue("wait_sel", 8'(ker_clk_sel), 8'd0);
         if (i < 9) tick();
      end
      src_rdy = 5'b11111;
      tick();
      checkValue("wait_switch_sel", 8'(ker_clk_sel), 8'd0);
      tick();
      checkValue("wait_new_sel", 8'(ker_clk_sel), 8'd3);
      checkValue("wait_new_on_req", 8'(src_on_req), 8'b01000);
      checkValue("wait_gate_closed", 8'(ker_gate_en), 8'd0);
      repeat (2) tick();
      checkValue("wait_gate_open", 8'(ker_gate_en), 8'd1);
      checkValue("wait_busy_done", 8'(busy), 8'd0);

      $display("[TB] 3->4 with source 4 never ready");
      src_rdy = 5'b01111;
      sel_req = 3'd4;
      repeat (3) tick();
      for (int i = 0; i < 16; i++) begin
         checkValue("tmo_on_req", 8'(src_on_req), 8'b11000);
         checkValue("tmo_not_yet", 8'(tmo_err), 8'd0);
         tick();
      end
      checkValue("tmo_set", 8'(tmo_err), 8'd1);
      checkValue("tmo_sel_kept", 8'(ker_clk_sel), 8'd3);
      checkValue("tmo_on_req_revert", 8'(src_on_req), 8'b01000);
      checkValue("tmo_gate_closed", 8'(ker_gate_en), 8'd0);
      repeat (2) tick();
      checkValue("tmo_gate_reopen", 8'(ker_gate_en), 8'd1);
      checkValue("tmo_retry_detect", 8'(busy), 8'd1);
      tick();
      checkValue("tmo_retry_gate", 8'(ker_gate_en), 8'd0);
      err_clr = 1'b1;
      sel_req = 3'd3;
      tick();
      err_clr = 1'b0;
      checkValue("tmo_cleared", 8'(tmo_err), 8'd0);
      begin
         int n = 0;
         while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
         end
         checkValue("tmo_retry_done", 8'(busy), 8'd0);
      end
      checkValue("tmo_second_set", 8'(tmo_err), 8'd1);
      checkValue("tmo_second_sel", 8'(ker_clk_sel), 8'd3);
      checkValue("tmo_second_gate", 8'(ker_gate_en), 8'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkValue("tmo_final_clear", 8'(tmo_err), 8'd0);

      $display("[TB] retarget 3->1 then 2 during GATE_OFF");
      src_rdy = 5'b11111;
      sel_req = 3'd1;
      tick();
      checkValue("rt_gate_off", 8'(ker_gate_en), 8'd0);
      sel_req = 3'd2;
      repeat (4) tick();
      checkValue("rt_first_target", 8'(ker_clk_sel), 8'd1);
      repeat (2) tick();
      checkValue("rt_gate_between", 8'(ker_gate_en), 8'd1);
      checkValue("rt_second_detect", 8'(busy), 8'd1);
      repeat (5) tick();
      checkValue("rt_second_target", 8'(ker_clk_sel), 8'd2);
      repeat (2) tick();
      checkValue("rt_gate_final", 8'(ker_gate_en), 8'd1);
      checkValue("rt_busy_final", 8'(busy), 8'd0);

      $display("[TB] reset asserted during WAIT_RDY");
      src_rdy = 5'b10111;
      sel_req = 3'd3;
      repeat (3) tick();
      checkValue("rst_pre_on_req", 8'(src_on_req), 8'b01100);
      #2;
      rst_n   = 1'b0;
      sel_req = 3'd0;
      #1;
      checkValue("rst_sel", 8'(ker_clk_sel), 8'd0);
      checkValue("rst_gate", 8'(ker_gate_en), 8'd1);
      checkValue("rst_on_req", 8'(src_on_req), 8'b00001);
      checkValue("rst_busy", 8'(busy), 8'd0);
      checkValue("rst_errs", 8'({sel_err, tmo_err}), 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      checkValue("rst_after_sel", 8'(ker_clk_sel), 8'd0);
      checkValue("rst_after_busy", 8'(busy), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
